// File: rtl/axi_mem_pkg.sv
// Shared types and address-mapping helpers for the burst memory slave and its
// read-channel engines.
package axi_mem_pkg;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_MEM_SIZE   = 256;
    localparam int DEF_LSB        = $clog2(DEF_DATA_WIDTH / 8);
    localparam int DEF_IDX_W      = $clog2(DEF_MEM_SIZE);

    localparam logic [1:0] RESP_OKAY = 2'b00;

    // Byte-offset bits below the word index.
    function automatic int addr_lsb(input int data_width);
        return $clog2(data_width / 8);
    endfunction

    // Word-index width; a one-word memory still needs one index bit.
    function automatic int idx_width(input int mem_size);
        return (mem_size > 1) ? $clog2(mem_size) : 1;
    endfunction

endpackage

// File: rtl/axi_burst_read_channel.sv
// One AXI-style read burst engine: accepts an AR request and streams beats
// from the shared array through a combinational lookup of the next word.
module axi_burst_read_channel
    import axi_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int IDX_W      = 8,
    parameter int LSB        = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic [7:0]            arlen,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    input  logic                  rready,
    output logic                  rlast,
    output logic [IDX_W-1:0]      rd_idx,
    input  logic [DATA_WIDTH-1:0] rd_word
);

    rd_state_t             state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [7:0]            len_q, len_d;
    logic [7:0]            beat_q, beat_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;
    logic                  rlast_q, rlast_d;
    logic                  arready_q, arready_d;

    // Only the word-index bits of the address select data.
    logic unused_addr;
    assign unused_addr = ^araddr;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        len_d     = len_q;
        beat_d    = beat_q;
        rdata_d   = rdata_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        arready_d = arready_q;
        rd_idx    = idx_q + IDX_W'(1);

        case (state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                rd_idx    = araddr[LSB +: IDX_W];
                if (arvalid && arready_q) begin
                    idx_d     = araddr[LSB +: IDX_W];
                    len_d     = arlen;
                    beat_d    = 8'd0;
                    rdata_d   = rd_word;
                    rvalid_d  = 1'b1;
                    rlast_d   = (arlen == 8'd0);
                    arready_d = 1'b0;
                    state_d   = R_DATA;
                end
            end
            R_DATA: begin
                if (rvalid_q && rready) begin
                    if (rlast_q) begin
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        arready_d = 1'b1;
                        state_d   = R_IDLE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        beat_d  = beat_q + 8'd1;
                        rdata_d = rd_word;
                        rlast_d = ((beat_q + 8'd1) == len_q);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= R_IDLE;
            idx_q     <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            arready_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            beat_q    <= beat_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            arready_q <= arready_d;
        end
    end

    assign arready = arready_q;
    assign rdata   = rdata_q;
    assign rvalid  = rvalid_q;
    assign rlast   = rlast_q;

endmodule

// File: rtl/axi_burst_memory_slave_2rd.sv
// Burst memory responder: one write channel and two independent read channels
// sharing a 1W/2R word array whose contents survive reset.
module axi_burst_memory_slave_2rd
    import axi_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_SIZE   = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic [7:0]            awlen,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  wvalid,
    output logic                  wready,
    input  logic                  wlast,
    output logic                  bvalid,
    input  logic                  bready,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic [7:0]            arlen,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    input  logic                  rready,
    output logic                  rlast,
    input  logic [ADDR_WIDTH-1:0] araddr_2,
    input  logic [7:0]            arlen_2,
    input  logic                  arvalid_2,
    output logic                  arready_2,
    output logic [DATA_WIDTH-1:0] rdata_2,
    output logic                  rvalid_2,
    input  logic                  rready_2,
    output logic                  rlast_2,
    output logic                  wlast_err
);

    localparam int LSB   = addr_lsb(DATA_WIDTH);
    localparam int IDX_W = idx_width(MEM_SIZE);

    logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

    wr_state_t        w_state_q, w_state_d;
    logic [IDX_W-1:0] w_idx_q, w_idx_d;
    logic [7:0]       w_len_q, w_len_d;
    logic [7:0]       w_beat_q, w_beat_d;
    logic             awready_q, awready_d;
    logic             wready_q, wready_d;
    logic             bvalid_q, bvalid_d;
    logic             wlast_err_q, wlast_err_d;
    logic             mem_we;

    logic unused_addr;
    assign unused_addr = ^awaddr;

    always_comb begin
        w_state_d   = w_state_q;
        w_idx_d     = w_idx_q;
        w_len_d     = w_len_q;
        w_beat_d    = w_beat_q;
        awready_d   = awready_q;
        wready_d    = wready_q;
        bvalid_d    = bvalid_q;
        wlast_err_d = wlast_err_q;
        mem_we      = 1'b0;

        case (w_state_q)
            W_IDLE: begin
                awready_d = 1'b1;
                if (awvalid && awready_q) begin
                    w_idx_d   = awaddr[LSB +: IDX_W];
                    w_len_d   = awlen;
                    w_beat_d  = 8'd0;
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (wvalid && wready_q) begin
                    mem_we = 1'b1;
                    // The beat count ends the burst; wlast is only cross-checked.
                    if (wlast != (w_beat_q == w_len_q)) begin
                        wlast_err_d = 1'b1;
                    end
                    if (w_beat_q == w_len_q) begin
                        wready_d  = 1'b0;
                        bvalid_d  = 1'b1;
                        w_state_d = W_RESP;
                    end else begin
                        w_idx_d  = w_idx_q + IDX_W'(1);
                        w_beat_d = w_beat_q + 8'd1;
                    end
                end
            end
            W_RESP: begin
                if (bvalid_q && bready) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
            default: begin
                w_state_d = W_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_q   <= W_IDLE;
            w_idx_q     <= '0;
            w_len_q     <= '0;
            w_beat_q    <= '0;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            wlast_err_q <= 1'b0;
        end else begin
            w_state_q   <= w_state_d;
            w_idx_q     <= w_idx_d;
            w_len_q     <= w_len_d;
            w_beat_q    <= w_beat_d;
            awready_q   <= awready_d;
            wready_q    <= wready_d;
            bvalid_q    <= bvalid_d;
            wlast_err_q <= wlast_err_d;
        end
    end

    // No reset on the array: stored frames must survive rst_n.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[w_idx_q] <= wdata;
        end
    end

    assign awready   = awready_q;
    assign wready    = wready_q;
    assign bvalid    = bvalid_q;
    assign wlast_err = wlast_err_q;

    logic [1:0][ADDR_WIDTH-1:0] ch_araddr;
    logic [1:0][7:0]            ch_arlen;
    logic [1:0]                 ch_arvalid;
    logic [1:0]                 ch_arready;
    logic [1:0][DATA_WIDTH-1:0] ch_rdata;
    logic [1:0]                 ch_rvalid;
    logic [1:0]                 ch_rready;
    logic [1:0]                 ch_rlast;
    logic [1:0][IDX_W-1:0]      ch_idx;
    logic [1:0][DATA_WIDTH-1:0] ch_word;

    assign ch_araddr  = {araddr_2, araddr};
    assign ch_arlen   = {arlen_2, arlen};
    assign ch_arvalid = {arvalid_2, arvalid};
    assign ch_rready  = {rready_2, rready};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            // Reads see the array before this cycle's write lands.
            assign ch_word[gi] = mem[ch_idx[gi]];

            axi_burst_read_channel #(
                .ADDR_WIDTH(ADDR_WIDTH),
                .DATA_WIDTH(DATA_WIDTH),
                .IDX_W     (IDX_W),
                .LSB       (LSB)
            ) u_rd (
                .clk     (clk),
                .rst_n   (rst_n),
                .araddr  (ch_araddr[gi]),
                .arlen   (ch_arlen[gi]),
                .arvalid (ch_arvalid[gi]),
                .arready (ch_arready[gi]),
                .rdata   (ch_rdata[gi]),
                .rvalid  (ch_rvalid[gi]),
                .rready  (ch_rready[gi]),
                .rlast   (ch_rlast[gi]),
                .rd_idx  (ch_idx[gi]),
                .rd_word (ch_word[gi])
            );
        end
    endgenerate

    assign arready   = ch_arready[0];
    assign rdata     = ch_rdata[0];
    assign rvalid    = ch_rvalid[0];
    assign rlast     = ch_rlast[0];
    assign arready_2 = ch_arready[1];
    assign rdata_2   = ch_rdata[1];
    assign rvalid_2  = ch_rvalid[1];
    assign rlast_2   = ch_rlast[1];

endmodule

// File: tb/tb_axi_burst_memory_slave_2rd.sv
// Randomized self-checking bench for the burst memory slave against a word-array
// reference model updated per completed write burst.
module tb_axi_burst_memory_slave_2rd;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic        wvalid, wready, wlast;
    logic        bvalid, bready;
    logic [31:0] araddr, araddr_2;
    logic [7:0]  arlen, arlen_2;
    logic        arvalid, arvalid_2, arready, arready_2;
    logic [31:0] rdata, rdata_2;
    logic        rvalid, rvalid_2, rready, rready_2, rlast, rlast_2;
    logic        wlast_err;

    int          vectors = 0;
    int          miscompares = 0;
    bit          exp_err = 1'b0;
    logic [31:0] model_mem [256];
    logic [31:0] wbuf [256];

    always #5 clk = ~clk;

    axi_burst_memory_slave_2rd #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_SIZE(256)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wvalid(wvalid), .wready(wready), .wlast(wlast),
        .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rready(rready), .rlast(rlast),
        .araddr_2(araddr_2), .arlen_2(arlen_2), .arvalid_2(arvalid_2), .arready_2(arready_2),
        .rdata_2(rdata_2), .rvalid_2(rvalid_2), .rready_2(rready_2), .rlast_2(rlast_2),
        .wlast_err(wlast_err)
    );

    function automatic logic get_arready(input int ch);
        return (ch == 0) ? arready : arready_2;
    endfunction
    function automatic logic get_rvalid(input int ch);
        return (ch == 0) ? rvalid : rvalid_2;
    endfunction
    function automatic logic get_rlast(input int ch);
        return (ch == 0) ? rlast : rlast_2;
    endfunction
    function automatic logic [31:0] get_rdata(input int ch);
        return (ch == 0) ? rdata : rdata_2;
    endfunction

    task automatic set_ar(input int ch, input logic [31:0] addr, input int len, input logic v);
        if (ch == 0) begin araddr = addr; arlen = 8'(len); arvalid = v; end
        else         begin araddr_2 = addr; arlen_2 = 8'(len); arvalid_2 = v; end
    endtask

    task automatic set_rready(input int ch, input logic v);
        if (ch == 0) rready = v; else rready_2 = v;
    endtask

    function automatic int word_idx(input logic [31:0] addr);
        return int'((addr >> 2) & 32'hFF);
    endfunction

    // mode 0: rready always high, 1: pattern 1,0,0 repeating, 2: random
    task automatic do_read(input int ch, input logic [31:0] addr, input int len, input int mode);
        int          idx, beat, cyc, p;
        bit          rr, prev_stall;
        logic [31:0] prev_data, exp;
        idx = word_idx(addr);
        @(negedge clk);
        set_ar(ch, addr, len, 1'b1);
        cyc = 0;
        while (get_arready(ch) !== 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
        vectors++;
        if (get_arready(ch) !== 1'b1) begin
            miscompares++;
            $display("FAIL ar_timeout ch%0d: arready=%b required 1", ch, get_arready(ch));
            set_ar(ch, addr, len, 1'b0);
            return;
        end
        @(negedge clk);
        set_ar(ch, addr, len, 1'b0);
        vectors++;
        if (get_rvalid(ch) !== 1'b1) begin
            miscompares++;
            $display("FAIL first_rvalid ch%0d: rvalid=%b required 1", ch, get_rvalid(ch));
        end
        beat = 0; cyc = 0; p = 0; prev_stall = 1'b0; prev_data = '0;
        while (beat <= len && cyc < 2000) begin
            rr = (mode == 0) ? 1'b1 : (mode == 1) ? (p % 3 == 0) : 1'($urandom_range(0, 1));
            p++;
            set_rready(ch, rr);
            vectors++;
            if (get_rvalid(ch) !== 1'b1) begin
                miscompares++;
                $display("FAIL rvalid_drop ch%0d beat %0d: rvalid=%b required 1", ch, beat, get_rvalid(ch));
                break;
            end
            exp = model_mem[(idx + beat) & 255];
            if (get_rdata(ch) !== exp || get_rlast(ch) !== (beat == len)) begin
                miscompares++;
                $display("FAIL rd_beat ch%0d beat %0d: rdata=%h rlast=%b required %h/%b",
                         ch, beat, get_rdata(ch), get_rlast(ch), exp, (beat == len));
            end
            if (prev_stall) begin
                vectors++;
                if (get_rdata(ch) !== prev_data) begin
                    miscompares++;
                    $display("FAIL stall_stable ch%0d: rdata=%h required %h", ch, get_rdata(ch), prev_data);
                end
            end
            prev_stall = !rr;
            prev_data  = get_rdata(ch);
            if (rr) beat++;
            @(negedge clk);
            cyc++;
        end
        set_rready(ch, 1'b0);
        vectors++;
        if (beat != len + 1 || get_rvalid(ch) !== 1'b0 || get_rlast(ch) !== 1'b0 || get_arready(ch) !== 1'b1) begin
            miscompares++;
            $display("FAIL rd_end ch%0d: beats=%0d rvalid=%b rlast=%b arready=%b required %0d/0/0/1",
                     ch, beat, get_rvalid(ch), get_rlast(ch), get_arready(ch), len + 1);
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input int len, input int bad_beat, input bit jitter);
        int idx, cyc;
        idx = word_idx(addr);
        @(negedge clk);
        awaddr = addr; awlen = 8'(len); awvalid = 1'b1;
        cyc = 0;
        while (awready !== 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
        vectors++;
        if (awready !== 1'b1) begin
            miscompares++;
            $display("FAIL aw_timeout: awready=%b required 1", awready);
            awvalid = 1'b0;
            return;
        end
        @(negedge clk);
        awvalid = 1'b0;
        vectors++;
        if (awready !== 1'b0 || wready !== 1'b1) begin
            miscompares++;
            $display("FAIL aw_accept: awready=%b wready=%b required 0/1", awready, wready);
        end
        for (int b = 0; b <= len; b++) begin
            if (jitter && $urandom_range(0, 3) == 0) begin wvalid = 1'b0; @(negedge clk); end
            wdata = wbuf[b]; wvalid = 1'b1;
            wlast = (b == len) ^ (b == bad_beat);
            if (b == bad_beat) exp_err = 1'b1;
            @(negedge clk);
            if (b < len) begin
                vectors++;
                if (bvalid !== 1'b0 || wready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL w_early_end beat %0d: bvalid=%b wready=%b required 0/1", b, bvalid, wready);
                end
            end
        end
        wvalid = 1'b0; wlast = 1'b0;
        for (int b = 0; b <= len; b++) model_mem[(idx + b) & 255] = wbuf[b];
        vectors++;
        if (bvalid !== 1'b1 || wready !== 1'b0) begin
            miscompares++;
            $display("FAIL bvalid_timing: bvalid=%b wready=%b required 1/0", bvalid, wready);
        end
        if (jitter) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                vectors++;
                if (bvalid !== 1'b1) begin
                    miscompares++;
                    $display("FAIL bvalid_hold: bvalid=%b required 1", bvalid);
                end
            end
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        vectors++;
        if (bvalid !== 1'b0 || awready !== 1'b1) begin
            miscompares++;
            $display("FAIL b_done: bvalid=%b awready=%b required 0/1", bvalid, awready);
        end
        vectors++;
        if (wlast_err !== exp_err) begin
            miscompares++;
            $display("FAIL wlast_err: got %b required %b", wlast_err, exp_err);
        end
    endtask

    task automatic idle_inputs();
        awaddr = '0; awlen = '0; awvalid = 1'b0; wdata = '0; wvalid = 1'b0; wlast = 1'b0;
        bready = 1'b0; araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;
        araddr_2 = '0; arlen_2 = '0; arvalid_2 = 1'b0; rready_2 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        vectors++;
        if ({awready, wready, bvalid, arready, arready_2, rvalid, rvalid_2, rlast, rlast_2, wlast_err} !== 10'b0
            || rdata !== 32'h0 || rdata_2 !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: ctl=%b rdata=%h rdata_2=%h required all zero",
                     {awready, wready, bvalid, arready, arready_2, rvalid, rvalid_2, rlast, rlast_2, wlast_err},
                     rdata, rdata_2);
        end
        rst_n = 1'b1;
        exp_err = 1'b0;
        @(negedge clk);
        vectors++;
        if (awready !== 1'b1 || arready !== 1'b1 || arready_2 !== 1'b1 || wready !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset: awready=%b arready=%b arready_2=%b wready=%b required 1/1/1/0",
                     awready, arready, arready_2, wready);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 256; i++) wbuf[i] = $urandom;
        do_write(32'h0, 255, -1, 1'b0);
        do_read(1, 32'h0, 255, 0);
    endtask

    task automatic test_single_write();
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0 + 32'(i);
        do_write(32'h10, 3, -1, 1'b0);
        vectors++;
        if (model_mem[4] !== 32'hA0 || model_mem[7] !== 32'hA3) begin
            miscompares++;
            $display("FAIL model_words_4_7: got %h/%h required 000000a0/000000a3", model_mem[4], model_mem[7]);
        end
    endtask

    task automatic test_read_ch1();
        do_read(0, 32'h10, 3, 0);
    endtask

    task automatic test_backpressure_ch2();
        do_read(1, 32'h10, 3, 1);
    endtask

    task automatic test_wrap_concurrency();
        logic [31:0] old0;
        logic [31:0] d [4];
        old0 = model_mem[0];
        for (int i = 0; i < 4; i++) d[i] = $urandom;
        d[2] = ~old0;
        @(negedge clk);
        vectors++;
        if (awready !== 1'b1 || arready !== 1'b1 || arready_2 !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_idle_ready: awready=%b arready=%b arready_2=%b required 1/1/1",
                     awready, arready, arready_2);
        end
        awaddr = 32'h3F8; awlen = 8'd3; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wdata = d[0]; wvalid = 1'b1; wlast = 1'b0;
        @(negedge clk);
        wdata = d[1];
        @(negedge clk);
        wdata = d[2];
        araddr = 32'h0; arlen = 8'd0; arvalid = 1'b1; rready = 1'b1;
        araddr_2 = 32'h0; arlen_2 = 8'd0; arvalid_2 = 1'b1; rready_2 = 1'b1;
        @(negedge clk);
        vectors++;
        if (rvalid !== 1'b1 || rdata !== old0 || rlast !== 1'b1) begin
            miscompares++;
            $display("FAIL same_cycle_ch1: rvalid=%b rdata=%h rlast=%b required 1/%h/1", rvalid, rdata, rlast, old0);
        end
        vectors++;
        if (rvalid_2 !== 1'b1 || rdata_2 !== old0 || rlast_2 !== 1'b1) begin
            miscompares++;
            $display("FAIL same_cycle_ch2: rvalid=%b rdata=%h rlast=%b required 1/%h/1", rvalid_2, rdata_2, rlast_2, old0);
        end
        arvalid = 1'b0; arvalid_2 = 1'b0; wdata = d[3]; wlast = 1'b1;
        @(negedge clk);
        wvalid = 1'b0; wlast = 1'b0; rready = 1'b0; rready_2 = 1'b0;
        vectors++;
        if (bvalid !== 1'b1 || rvalid !== 1'b0 || rvalid_2 !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_burst_end: bvalid=%b rvalid=%b rvalid_2=%b required 1/0/0", bvalid, rvalid, rvalid_2);
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        model_mem[254] = d[0]; model_mem[255] = d[1]; model_mem[0] = d[2]; model_mem[1] = d[3];
        do_read(0, 32'h0, 0, 0);
        do_read(1, 32'h0, 0, 0);
        do_read(0, 32'h3F8, 3, 2);
    endtask

    task automatic test_wlast_err();
        wbuf[0] = 32'h1111_0000; wbuf[1] = 32'h1111_0001;
        do_write(32'h80, 1, 0, 1'b0);
        do_read(0, 32'h80, 1, 0);
        wbuf[0] = 32'h2222_0000;
        do_write(32'h90, 0, -1, 1'b0);
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk);
        araddr = 32'h40; arlen = 8'd7; arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0; rready = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (rvalid !== 1'b1 || rdata !== model_mem[18]) begin
            miscompares++;
            $display("FAIL beat2_before_reset: rvalid=%b rdata=%h required 1/%h", rvalid, rdata, model_mem[18]);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (rvalid !== 1'b0 || rlast !== 1'b0 || bvalid !== 1'b0 || arready !== 1'b0 || wlast_err !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: rvalid=%b rlast=%b bvalid=%b arready=%b wlast_err=%b required all 0",
                     rvalid, rlast, bvalid, arready, wlast_err);
        end
        idle_inputs();
        exp_err = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (arready !== 1'b1 || arready_2 !== 1'b1 || awready !== 1'b1 || rvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL after_release: arready=%b arready_2=%b awready=%b rvalid=%b required 1/1/1/0",
                     arready, arready_2, awready, rvalid);
        end
        do_read(0, 32'h40, 7, 0);
    endtask

    task automatic test_back_to_back();
        fork
            do_read(0, 32'h100, 5, 0);
            do_read(1, 32'h104, 7, 0);
        join
        fork
            do_read(0, 32'h3F0, 6, 2);
            do_read(1, 32'h3F0, 6, 1);
        join
    endtask

    task automatic test_random();
        int len, op, bad;
        for (int it = 0; it < 30; it++) begin
            op = $urandom_range(0, 2);
            len = $urandom_range(0, 15);
            if (op == 0) begin
                for (int i = 0; i <= len; i++) wbuf[i] = $urandom;
                bad = ($urandom_range(0, 7) == 0) ? $urandom_range(0, len) : -1;
                do_write($urandom, len, bad, 1'b1);
            end else if (op == 1) begin
                do_read($urandom_range(0, 1), $urandom, len, 2);
            end else begin
                fork
                    do_read(0, $urandom, len, 2);
                    do_read(1, $urandom, $urandom_range(0, 15), 2);
                join
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fill();
        test_single_write();
        test_read_ch1();
        test_backpressure_ch2();
        test_wrap_concurrency();
        test_wlast_err();
        test_reset_mid_read();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
